modmul_sched: RTL

//  Shares one modmul pipeline among NREQ independent requesters (e.g. NTT lanes and the vector ALU).

---
 rtl/vp_modmul_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/modmul_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vp_modmul_pkg.sv
// Shared types for the modmul issue path.
//   MODMUL_LATENCY : pipeline depth of the instantiated modmul core
//   mm_req_t       : one modmul operation at the default 64-bit width
//   mm_tag_t       : in-flight tag {valid, requester id}, id wide enough for 8 requesters
package vp_modmul_pkg;

  localparam int unsigned MODMUL_LATENCY = 5;
  localparam int unsigned MM_DATA_W      = 64;
  localparam int unsigned MM_MWIDTH_W    = $clog2(MM_DATA_W);
  localparam int unsigned MM_ID_W        = 3;

  typedef struct packed {
    logic [MM_DATA_W-1:0]   opa;
    logic [MM_DATA_W-1:0]   opb;
    logic [MM_DATA_W-1:0]   mod;
    logic [MM_DATA_W-1:0]   imod;
    logic [MM_MWIDTH_W-1:0] mwidth;
  } mm_req_t;

  typedef struct packed {
    logic               v;
    logic [MM_ID_W-1:0] id;
  } mm_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : index where the search starts (held by the parent)
//   gnt     : one-hot grant, zero when no request
//   gnt_idx : index of the granted request (0 when no grant)
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!found && req[IW'(idx)]) begin
        found            = 1'b1;
        gnt[IW'(idx)]    = 1'b1;
        gnt_idx          = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/modmul_sched.sv
// Round-robin scheduler sharing one modmul pipeline among NREQ requesters.
//   clk_i, rst        : clock, async active-high reset
//   req_*_i / ready_o : per-requester operands and valid; ready is the combinational grant
//   mm_*_o            : registered issue port to the modmul core
//   mm_valid_i/res_i  : modmul result port, exactly LATENCY cycles after issue
//   rsp_valid_o/res_o : one-hot result strobe steered to the issuing requester
//   err_o             : sticky orphan-result / missing-result flag
module modmul_sched
  import vp_modmul_pkg::*;
#(
  parameter  int unsigned NREQ         = 4,
  parameter  int unsigned DATA_W       = 64,
  parameter  int unsigned LATENCY      = MODMUL_LATENCY,
  parameter  int unsigned MAX_INFLIGHT = 4,
  localparam int unsigned MW_W         = $clog2(DATA_W),
  localparam int unsigned ID_W         = $clog2(NREQ),
  localparam int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid_i,
  output logic [NREQ-1:0]             req_ready_o,
  input  logic [NREQ-1:0][DATA_W-1:0] req_opa_i,
  input  logic [NREQ-1:0][DATA_W-1:0] req_opb_i,
  input  logic [NREQ-1:0][DATA_W-1:0] req_mod_i,
  input  logic [NREQ-1:0][DATA_W-1:0] req_imod_i,
  input  logic [NREQ-1:0][MW_W-1:0]   req_mwidth_i,
  output logic                        mm_valid_o,
  output logic [DATA_W-1:0]           mm_opa_o,
  output logic [DATA_W-1:0]           mm_opb_o,
  output logic [DATA_W-1:0]           mm_mod_o,
  output logic [DATA_W-1:0]           mm_imod_o,
  output logic [MW_W-1:0]             mm_mwidth_o,
  input  logic                        mm_valid_i,
  input  logic [DATA_W-1:0]           mm_res_i,
  output logic [NREQ-1:0]             rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_res_o,
  output logic                        err_o
);

  typedef struct packed {
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] mod;
    logic [DATA_W-1:0] imod;
    logic [MW_W-1:0]   mwidth;
  } req_t;

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt [NREQ];
  logic [NREQ-1:0]  elig, gnt, dec_oh, ret_oh;
  logic [ID_W-1:0]  gnt_idx;
  req_t             issue_q;
  logic             issue_v;
  logic [ID_W-1:0]  issue_id;
  tag_t             tag_pipe [LATENCY];
  tag_t             head;

  // Grant is blocked while in reset so no requester sees a handshake the registers ignore.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      elig[i] = req_valid_i[i] && (cnt[i] < CNT_W'(MAX_INFLIGHT)) && !rst;
  end

  rr_arbiter #(.N(NREQ)) u_arb (
    .req     (elig),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready_o = gnt;

  assign head   = tag_pipe[LATENCY-1];
  // A head tag frees its requester's slot whether or not the result showed up.
  assign dec_oh = head.v ? (NREQ'(1) << head.id) : '0;
  assign ret_oh = (head.v && mm_valid_i) ? (NREQ'(1) << head.id) : '0;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      issue_v  <= 1'b0;
      issue_q  <= '0;
      issue_id <= '0;
    end else begin
      issue_v <= |gnt;
      if (|gnt) begin
        ptr      <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        issue_id <= gnt_idx;
        issue_q  <= '{opa:    req_opa_i[gnt_idx],
                      opb:    req_opb_i[gnt_idx],
                      mod:    req_mod_i[gnt_idx],
                      imod:   req_imod_i[gnt_idx],
                      mwidth: req_mwidth_i[gnt_idx]};
      end
    end
  end

  assign mm_valid_o  = issue_v;
  assign mm_opa_o    = issue_q.opa;
  assign mm_opb_o    = issue_q.opb;
  assign mm_mod_o    = issue_q.mod;
  assign mm_imod_o   = issue_q.imod;
  assign mm_mwidth_o = issue_q.mwidth;

  // Tag pipe shifts every cycle so its head aligns with mm_valid_i.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{v: issue_v, id: issue_id};
      for (int unsigned i = 1; i < LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (gnt[i] && !dec_oh[i])
          cnt[i] <= cnt[i] + CNT_W'(1);
        else if (dec_oh[i] && !gnt[i] && cnt[i] != '0)
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      rsp_valid_o <= '0;
      rsp_res_o   <= '0;
      err_o       <= 1'b0;
    end else begin
      rsp_valid_o <= ret_oh;
      if (|ret_oh) rsp_res_o <= mm_res_i;
      if (mm_valid_i != head.v) err_o <= 1'b1;
    end
  end

endmodule
